// File: rtl/spi_arb_seq.sv
// Two-requester burst sequencer and arbiter in front of a byte-wide SPI master.
// Define SPI_ARB_RR_EN for round-robin ties; otherwise requester 0 has priority.
module spi_arb_seq #(
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 4,
    parameter int GAP_CLKS = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [1:0]          req_i,
    input  logic [2*LEN_W-1:0]  len_i,
    input  logic [2*DATA_W-1:0] tx_data_i,
    output logic [1:0]          tx_rdy_o,
    output logic [DATA_W-1:0]   rx_data_o,
    output logic [1:0]          rx_vld_o,
    output logic [1:0]          done_o,
    output logic [1:0]          grant_o,
    output logic                m_wr_o,
    output logic                m_csn_o,
    output logic [DATA_W-1:0]   m_data_o,
    input  logic                m_busy_i,
    input  logic [DATA_W-1:0]   m_data_i
);

    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO,
        S_CLOSE,
        S_DONE,
        S_GAP
    } state_t;

    state_t             state, state_d;
    logic               win, win_d;
    logic [LEN_W-1:0]   cnt, cnt_d;
    logic [GAP_W-1:0]   gap, gap_d;
    logic [1:0]         tx_rdy_d, rx_vld_d, done_d, grant_d;
    logic [DATA_W-1:0]  rx_data_d, mdata_d;
    logic               wr_d, csn_d;
    logic               pick;
    logic [LEN_W-1:0]   pick_len;
    logic [DATA_W-1:0]  win_tx;
    logic [1:0]         win_oh;

`ifdef SPI_ARB_RR_EN
    logic last, last_d;

    // On a tie the requester that did not own the last burst wins.
    always_comb begin
        if (req_i == 2'b11) pick = ~last;
        else                pick = req_i[1];
    end
`else
    always_comb pick = ~req_i[0];
`endif

    assign pick_len = pick ? len_i[2*LEN_W-1:LEN_W] : len_i[LEN_W-1:0];
    assign win_tx   = win ? tx_data_i[2*DATA_W-1:DATA_W]
                          : tx_data_i[DATA_W-1:0];
    assign win_oh   = {win, ~win};

    always_comb begin
        state_d   = state;
        win_d     = win;
        cnt_d     = cnt;
        gap_d     = gap;
        grant_d   = grant_o;
        rx_data_d = rx_data_o;
        mdata_d   = m_data_o;
        tx_rdy_d  = 2'b00;
        rx_vld_d  = 2'b00;
        done_d    = 2'b00;
        wr_d      = 1'b0;
        csn_d     = 1'b1;
`ifdef SPI_ARB_RR_EN
        last_d    = last;
`endif
        unique case (state)
            S_IDLE: begin
                if (|req_i) state_d = S_ARB;
            end
            S_ARB: begin
                if (|req_i) begin
                    win_d   = pick;
                    grant_d = {pick, ~pick};
                    cnt_d   = pick_len;
`ifdef SPI_ARB_RR_EN
                    last_d  = pick;
`endif
                    state_d = (pick_len == '0) ? S_DONE : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                wr_d     = 1'b1;
                csn_d    = 1'b0;
                mdata_d  = win_tx;
                tx_rdy_d = win_oh;
                state_d  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                csn_d = 1'b0;
                if (m_busy_i) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                csn_d = 1'b0;
                if (!m_busy_i) begin
                    rx_data_d = m_data_i;
                    rx_vld_d  = win_oh;
                    cnt_d     = cnt - 1'b1;
                    state_d   = (cnt == LEN_W'(1)) ? S_CLOSE : S_LOAD;
                end
            end
            S_CLOSE: begin
                // Write strobe with csn high makes the master release select.
                wr_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = win_oh;
                grant_d = 2'b00;
                gap_d   = GAP_W'(GAP_CLKS - 1);
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap == '0) state_d = S_IDLE;
                else           gap_d   = gap - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= S_IDLE;
            win       <= 1'b0;
            cnt       <= '0;
            gap       <= '0;
            grant_o   <= 2'b00;
            tx_rdy_o  <= 2'b00;
            rx_vld_o  <= 2'b00;
            done_o    <= 2'b00;
            rx_data_o <= '0;
            m_wr_o    <= 1'b0;
            m_csn_o   <= 1'b1;
            m_data_o  <= '0;
        end else begin
            state     <= state_d;
            win       <= win_d;
            cnt       <= cnt_d;
            gap       <= gap_d;
            grant_o   <= grant_d;
            tx_rdy_o  <= tx_rdy_d;
            rx_vld_o  <= rx_vld_d;
            done_o    <= done_d;
            rx_data_o <= rx_data_d;
            m_wr_o    <= wr_d;
            m_csn_o   <= csn_d;
            m_data_o  <= mdata_d;
        end
    end

`ifdef SPI_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) last <= 1'b1;
        else         last <= last_d;
    end
`endif

endmodule

// File: tb/tb_spi_arb_seq.sv
// Scoreboard bench for spi_arb_seq with a behavioural SPI master and loopback slave.
module tb_spi_arb_seq;

    typedef struct packed {
        logic       dn;
        logic       who;
        logic [7:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req;
    logic [7:0]  len;
    logic [15:0] tx_data;
    logic [1:0]  tx_rdy, rx_vld, done, grant;
    logic [7:0]  rx_data, m_data;
    logic        m_wr, m_csn;

    logic        s_busy, s_start, s_csn, s_prev;
    logic [7:0]  s_sh, s_rx, xmask;
    int          s_cnt;

    logic [7:0]  txb [2][16];
    logic [3:0]  ptr [2];
    int          wr_cnt, csn_rise, hi_run, hi_last;

    ev_t         exp_ev[$];
    logic [7:0]  exp_wr[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    spi_arb_seq dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (req),
        .len_i     (len),
        .tx_data_i (tx_data),
        .tx_rdy_o  (tx_rdy),
        .rx_data_o (rx_data),
        .rx_vld_o  (rx_vld),
        .done_o    (done),
        .grant_o   (grant),
        .m_wr_o    (m_wr),
        .m_csn_o   (m_csn),
        .m_data_o  (m_data),
        .m_busy_i  (s_busy),
        .m_data_i  (s_rx)
    );

    assign tx_data = {txb[1][ptr[1]], txb[0][ptr[0]]};

    // Master model: registered wr, 6-clock byte, slave returns byte ^ xmask.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_busy  <= 1'b0;
            s_start <= 1'b0;
            s_csn   <= 1'b1;
            s_sh    <= 8'h00;
            s_rx    <= 8'h00;
            s_cnt   <= 0;
        end else begin
            s_start <= 1'b0;
            if (m_wr) begin
                s_csn <= m_csn;
                if (!m_csn) begin
                    s_sh    <= m_data;
                    s_start <= 1'b1;
                end
            end
            if (s_start) begin
                s_busy <= 1'b1;
                s_cnt  <= 6;
            end else if (s_busy) begin
                if (s_cnt == 1) begin
                    s_busy <= 1'b0;
                    s_rx   <= s_sh ^ xmask;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr[0] <= 4'd0;
            ptr[1] <= 4'd0;
        end else begin
            if (tx_rdy[0]) ptr[0] <= ptr[0] + 4'd1;
            if (tx_rdy[1]) ptr[1] <= ptr[1] + 4'd1;
        end
    end

    always @(posedge clk) begin
        s_prev <= s_csn;
        if (m_wr) wr_cnt <= wr_cnt + 1;
        if (s_csn && !s_prev) csn_rise <= csn_rise + 1;
        if (s_csn) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run != 0) hi_last <= hi_run;
            hi_run <= 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected output %0h, nothing queued", nm, act);
    endtask

    // Monitor: pop and compare whenever the DUT presents an output.
    initial begin
        ev_t        e;
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (m_wr && !m_csn) begin
                    if (exp_wr.size() == 0) unexpected("m_wr", 32'(m_data));
                    else begin
                        w = exp_wr.pop_front();
                        check("m_data", 32'(m_data), 32'(w));
                    end
                end
                if (rx_vld != 2'b00) begin
                    if (exp_ev.size() == 0) unexpected("rx_vld", 32'(rx_vld));
                    else begin
                        e = exp_ev.pop_front();
                        check("rx_vld", 32'(rx_vld),
                              e.dn ? 32'd0 : (e.who ? 32'd2 : 32'd1));
                        check("rx_data", 32'(rx_data), 32'(e.data));
                    end
                end
                if (done != 2'b00) begin
                    if (exp_ev.size() == 0) unexpected("done", 32'(done));
                    else begin
                        e = exp_ev.pop_front();
                        check("done", 32'(done),
                              !e.dn ? 32'd0 : (e.who ? 32'd2 : 32'd1));
                    end
                end
            end
        end
    end

    task automatic load(input int k, input int i, input logic [7:0] b);
        txb[k][4'(int'(ptr[k]) + i)] = b;
    endtask

    task automatic exp_byte(input logic k, input logic [7:0] b);
        exp_wr.push_back(b);
        exp_ev.push_back('{dn: 1'b0, who: k, data: b ^ xmask});
    endtask

    task automatic exp_done(input logic k);
        exp_ev.push_back('{dn: 1'b1, who: k, data: 8'h00});
    endtask

    task automatic wait_done(input logic [1:0] mask, input string nm);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            req = req & ~done;
            if ((req & mask) == 2'b00) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check({nm, "_timeout"}, 32'(req & mask), 32'd0);
            req = 2'b00;
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrc, rise0, g, d;
        logic [3:0] p0;
        bit seen;
        rstn   = 1'b0;
        req    = 2'b00;
        len    = 8'h00;
        xmask  = 8'h5A;
        wr_cnt = 0;
        csn_rise = 0;
        hi_run = 0;
        hi_last = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) txb[k][i] = 8'h00;

        repeat (5) @(negedge clk);
        check("rst_csn", 32'(m_csn), 32'd1);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_rdy", 32'(tx_rdy), 32'd0);
        check("rst_rx_vld", 32'(rx_vld), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr", 32'(m_wr), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        rstn = 1'b1;
        wrc = wr_cnt;
        repeat (100) @(negedge clk);
        check("idle_no_wr", 32'(wr_cnt - wrc), 32'd0);

        // First tie, both len 1: requester 0 wins in either mode.
        load(0, 0, 8'h11);
        load(1, 0, 8'h22);
        len = 8'h11;
        exp_byte(1'b0, 8'h11); exp_done(1'b0);
        exp_byte(1'b1, 8'h22); exp_done(1'b1);
        req = 2'b11;
        wait_done(2'b11, "tie1");

        // Single burst with plain loopback.
        xmask = 8'h00;
        load(0, 0, 8'hA5); load(0, 1, 8'h3C); load(0, 2, 8'hFF);
        len = 8'h03;
        exp_byte(1'b0, 8'hA5);
        exp_byte(1'b0, 8'h3C);
        exp_byte(1'b0, 8'hFF);
        exp_done(1'b0);
        rise0 = csn_rise;
        p0 = ptr[0];
        req = 2'b01;
        @(negedge clk);
        check("grant_n1", 32'(grant), 32'd0);
        @(negedge clk);
        check("grant_n2", 32'(grant), 32'd1);
        check("wr_n2", 32'(m_wr), 32'd0);
        @(negedge clk);
        check("wr_n3", 32'(m_wr), 32'd1);
        wait_done(2'b01, "single");
        check("single_csn_rises", 32'(csn_rise - rise0), 32'd1);
        check("single_tx_rdy", 32'(ptr[0] - p0), 32'd3);
        xmask = 8'h5A;

        // Second tie after requester 0 owned the bus last.
        load(0, 0, 8'h33);
        load(1, 0, 8'h44);
        len = 8'h11;
`ifdef SPI_ARB_RR_EN
        exp_byte(1'b1, 8'h44); exp_done(1'b1);
        exp_byte(1'b0, 8'h33); exp_done(1'b0);
`else
        exp_byte(1'b0, 8'h33); exp_done(1'b0);
        exp_byte(1'b1, 8'h44); exp_done(1'b1);
`endif
        req = 2'b11;
        wait_done(2'b11, "tie2");

        // Zero length on requester 1.
        len = 8'h00;
        exp_done(1'b1);
        wrc = wr_cnt;
        g = -1;
        d = -1;
        req = 2'b10;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (grant == 2'b10 && g < 0) g = i;
            if (done[1]) begin
                d = i;
                req = 2'b00;
                break;
            end
        end
        check("zero_done_seen", 32'(d >= 0 && g >= 0), 32'd1);
        check("zero_done_lat_le3", 32'(d - g <= 3), 32'd1);
        repeat (8) @(negedge clk);
        check("zero_no_wr", 32'(wr_cnt - wrc), 32'd0);

        // Reset during the second byte of a 4-byte burst.
        load(0, 0, 8'h01); load(0, 1, 8'h02);
        load(0, 2, 8'h03); load(0, 3, 8'h04);
        len = 8'h04;
        exp_byte(1'b0, 8'h01);
        exp_wr.push_back(8'h02);
        req = 2'b01;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_vld[0]) begin
                seen = 1;
                break;
            end
        end
        check("mid_first_rx", 32'(seen), 32'd1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_busy) begin
                seen = 1;
                break;
            end
        end
        check("mid_second_busy", 32'(seen), 32'd1);
        rstn = 1'b0;
        req = 2'b00;
        @(negedge clk);
        check("mid_rst_csn", 32'(m_csn), 32'd1);
        check("mid_rst_grant", 32'(grant), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_wr_q_empty", 32'(exp_wr.size()), 32'd0);
        check("mid_ev_q_empty", 32'(exp_ev.size()), 32'd0);

        // Fresh burst after reset on requester 1.
        load(1, 0, 8'hC3); load(1, 1, 8'h7E);
        len = 8'h20;
        exp_byte(1'b1, 8'hC3);
        exp_byte(1'b1, 8'h7E);
        exp_done(1'b1);
        req = 2'b10;
        wait_done(2'b10, "fresh");

        // Back-to-back single bytes: select must stay high for the gap.
        load(0, 0, 8'h5C);
        len = 8'h01;
        exp_byte(1'b0, 8'h5C); exp_done(1'b0);
        req = 2'b01;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done[0]) break;
        end
        req = 2'b00;
        @(negedge clk);
        load(0, 0, 8'hE7);
        exp_byte(1'b0, 8'hE7); exp_done(1'b0);
        req = 2'b01;
        wait_done(2'b01, "gap");
        check("gap_csn_high_ge4", 32'(hi_last >= 4), 32'd1);

        repeat (10) @(negedge clk);
        check("end_wr_q_empty", 32'(exp_wr.size()), 32'd0);
        check("end_ev_q_empty", 32'(exp_ev.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
